// File: rtl/cpu_program_feeder_if.sv
// Host/CPU-side bundle of the program feeder: load/clear/start controls in,
// registered CPU drive (rst, inbits) and run status out.
interface cpu_program_feeder_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              clear;
  logic              start;
  logic              cpu_rst;
  logic [3:0]        cpu_inbits;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;
  logic              overflow;

  modport master (
    output wr_en, wr_data, clear, start,
    input  cpu_rst, cpu_inbits, busy, done, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, clear, start,
    output cpu_rst, cpu_inbits, busy, done, count, overflow
  );
endinterface

// File: rtl/cpu_program_feeder.sv
// Stores opcode/operand pairs and replays them onto stack_cpu's nibble bus after a CPU reset.
// Run takes RST_CYCLES + sum(L) + 1 cycles to done; no backpressure, controls ignored while busy.
module cpu_program_feeder #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int RST_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  cpu_program_feeder_if.slave bus
);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, CPURST, FETCH, EXEC, FINISH} state_t;

  state_t            state, state_n;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [2:0]        k, k_n;
  logic [RW-1:0]     rcnt, rcnt_n;
  logic              cpu_rst_q, busy_q, done_q;
  logic [3:0]        inbits_q, inbits_n;
  logic              full, wr_accept, wr_drop, last_entry;

  // Cycles per instruction, fetch included, as the CPU consumes them.
  function automatic logic [2:0] instr_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8: instr_len = 3'd3;
      4'h3, 4'h4:                         instr_len = 3'd2;
      4'h9:                               instr_len = 3'd4;
      default:                            instr_len = 3'd2;
    endcase
  endfunction

  assign full       = (count_q == (ADDR_W+1)'(DEPTH));
  assign wr_accept  = (state == IDLE) && bus.wr_en && !bus.clear && !full;
  assign wr_drop    = (state == IDLE) && bus.wr_en && !bus.clear && full;
  assign last_entry = (({1'b0, pc} + (ADDR_W+1)'(1)) == count_q);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    k_n     = k;
    rcnt_n  = rcnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (count_q != '0) begin
            state_n = CPURST;
            rcnt_n  = '0;
          end else begin
            state_n = FINISH;
          end
        end
      end
      CPURST: begin
        if (rcnt == RW'(RST_CYCLES - 1)) begin
          state_n = FETCH;
          pc_n    = '0;
        end else begin
          rcnt_n = rcnt + RW'(1);
        end
      end
      FETCH: begin
        state_n = EXEC;
        k_n     = 3'd1;
      end
      EXEC: begin
        if (k == instr_len(mem[pc][3:0]) - 3'd1) begin
          if (last_entry) begin
            state_n = FINISH;
          end else begin
            state_n = FETCH;
            pc_n    = pc + ADDR_W'(1);
          end
        end else begin
          k_n = k + 3'd1;
        end
      end
      FINISH: begin
        state_n = IDLE;
        pc_n    = '0;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered from the next state so each nibble lands in its state's cycle.
    inbits_n = 4'h0;
    if (state_n == FETCH)     inbits_n = mem[pc_n][3:0];
    else if (state_n == EXEC) inbits_n = mem[pc_n][7:4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      k          <= '0;
      rcnt       <= '0;
      cpu_rst_q  <= 1'b0;
      inbits_q   <= 4'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      k         <= k_n;
      rcnt      <= rcnt_n;
      cpu_rst_q <= (state_n == CPURST);
      inbits_q  <= inbits_n;
      busy_q    <= (state_n != IDLE);
      done_q    <= (state_n == FINISH);
      if ((state == IDLE) && bus.clear) begin
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else if (wr_accept) begin
        count_q <= count_q + (ADDR_W+1)'(1);
      end else if (wr_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[count_q[ADDR_W-1:0]] <= bus.wr_data;
  end

  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.cpu_inbits = inbits_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_cpu_program_feeder.sv
// Randomized and directed bench for cpu_program_feeder against a per-cycle trace model.
module tb_cpu_program_feeder;
  localparam int DEPTH = 16, ADDR_W = 4, RST_CYCLES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] prog [$];

  cpu_program_feeder_if #(.ADDR_W(ADDR_W)) bus ();

  cpu_program_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int len_of(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8: return 3;
      4'h3, 4'h4:                         return 2;
      4'h9:                               return 4;
      default:                            return 2;
    endcase
  endfunction

  function automatic int run_len();
    int n = 0;
    if (prog.size() == 0) return 1;
    foreach (prog[i]) n += len_of(prog[i][3:0]);
    return RST_CYCLES + n + 1;
  endfunction

  task automatic do_clear(input bit with_write);
    @(negedge clk);
    bus.clear   = 1'b1;
    bus.wr_en   = with_write;
    bus.wr_data = 8'h11;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.wr_en = 1'b0;
    prog.delete();
  endtask

  // Leaves wr_en high on the final entry so a following start lands one cycle later.
  task automatic load(input logic [7:0] p [$]);
    foreach (p[i]) begin
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_data = p[i];
      if (prog.size() < DEPTH) prog.push_back(p[i]);
    end
  endtask

  // Expected {cpu_rst, inbits, busy, done} per cycle after start, plus one idle cycle.
  task automatic run_check(input string name, input bit disturb, output int done_at);
    logic [6:0] exp_q [$];
    logic [6:0] obs;
    logic [ADDR_W:0] cnt_before;
    if (prog.size() > 0) begin
      repeat (RST_CYCLES) exp_q.push_back({1'b1, 4'h0, 1'b1, 1'b0});
      foreach (prog[i]) begin
        exp_q.push_back({1'b0, prog[i][3:0], 1'b1, 1'b0});
        repeat (len_of(prog[i][3:0]) - 1) exp_q.push_back({1'b0, prog[i][7:4], 1'b1, 1'b0});
      end
    end
    exp_q.push_back({1'b0, 4'h0, 1'b1, 1'b1});
    exp_q.push_back({1'b0, 4'h0, 1'b0, 1'b0});

    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.clear = 1'b0;
    cnt_before = bus.count;
    n_cmp++;
    if (bus.count !== (ADDR_W+1)'(prog.size())) begin
      n_err++;
      $display("FAIL %s count_before_start: got %0d want %0d", name, bus.count, prog.size());
    end
    bus.start = 1'b1;
    done_at = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      bus.clear = 1'b0;
      if (disturb && i == exp_q.size() / 2) begin
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.clear   = 1'b1;
        bus.wr_data = 8'($urandom);
      end
      obs = {bus.cpu_rst, bus.cpu_inbits, bus.busy, bus.done};
      n_cmp++;
      if (obs !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s trace[%0d]: got rst=%b bits=%h busy=%b done=%b want rst=%b bits=%h busy=%b done=%b",
                 name, i, obs[6], obs[5:2], obs[1], obs[0],
                 exp_q[i][6], exp_q[i][5:2], exp_q[i][1], exp_q[i][0]);
      end
      if (obs[0] === 1'b1 && done_at < 0) done_at = i + 1;
    end
    n_cmp++;
    if (bus.count !== cnt_before) begin
      n_err++;
      $display("FAIL %s count_after_run: got %0d want %0d", name, bus.count, cnt_before);
    end
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.wr_data = 0; bus.clear = 0; bus.start = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.cpu_rst, bus.cpu_inbits, bus.busy, bus.done, bus.count, bus.overflow} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_values: got rst=%b bits=%h busy=%b done=%b count=%0d ovf=%b want all zero",
               bus.cpu_rst, bus.cpu_inbits, bus.busy, bus.done, bus.count, bus.overflow);
    end
  endtask

  task automatic test_add_program();
    int d;
    do_clear(1'b0);
    load('{8'h31, 8'h51, 8'h08, 8'h03, 8'h04});
    run_check("add", 1'b0, d);
    n_cmp++;
    if (d !== 16) begin
      n_err++;
      $display("FAIL add_run_length: got %0d want 16", d);
    end
    run_check("add_rerun", 1'b0, d);
  endtask

  task automatic test_mul_program();
    int d;
    do_clear(1'b0);
    load('{8'h71, 8'h61, 8'h09, 8'h03, 8'h02, 8'h04});
    run_check("mul", 1'b0, d);
    n_cmp++;
    if (d !== 20) begin
      n_err++;
      $display("FAIL mul_run_length: got %0d want 20", d);
    end
  endtask

  task automatic test_overflow_clear();
    logic [7:0] p [$];
    int d;
    do_clear(1'b0);
    for (int i = 0; i <= DEPTH; i++) p.push_back(8'($urandom));
    load(p);
    @(negedge clk);
    bus.wr_en = 1'b0;
    n_cmp++;
    if (bus.count !== 5'd16 || bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL overflow: got count=%0d ovf=%b want count=16 ovf=1", bus.count, bus.overflow);
    end
    do_clear(1'b1);
    n_cmp++;
    if (bus.count !== 5'd0 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL clear_wins: got count=%0d ovf=%b want count=0 ovf=0", bus.count, bus.overflow);
    end
    run_check("empty", 1'b0, d);
    n_cmp++;
    if (d !== 1) begin
      n_err++;
      $display("FAIL empty_run_length: got %0d want 1", d);
    end
  endtask

  task automatic test_ignore_while_busy();
    int d;
    do_clear(1'b0);
    load('{8'h31, 8'h51, 8'h08, 8'h03, 8'h04});
    run_check("busy_ignore", 1'b1, d);
    n_cmp++;
    if (d !== 16) begin
      n_err++;
      $display("FAIL busy_ignore_run_length: got %0d want 16", d);
    end
  endtask

  task automatic test_reset_midrun();
    do_clear(1'b0);
    load('{8'h31, 8'h51, 8'h08, 8'h03, 8'h04});
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.start = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    n_cmp++;
    if (bus.cpu_inbits !== 4'h0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrun_exec_slot: got bits=%h busy=%b want bits=0 busy=1", bus.cpu_inbits, bus.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({bus.cpu_rst, bus.cpu_inbits, bus.busy, bus.done, bus.count} !== 12'h0) begin
      n_err++;
      $display("FAIL midrun_reset: got rst=%b bits=%h busy=%b done=%b count=%0d want all zero",
               bus.cpu_rst, bus.cpu_inbits, bus.busy, bus.done, bus.count);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL midrun_no_done[%0d]: got done=%b busy=%b want 0 0", i, bus.done, bus.busy);
      end
    end
    prog.delete();
  endtask

  task automatic test_noop_program();
    int d;
    do_clear(1'b0);
    load('{8'h90, 8'h9B, 8'h9F});
    run_check("noop", 1'b0, d);
    n_cmp++;
    if (d !== RST_CYCLES + 6 + 1) begin
      n_err++;
      $display("FAIL noop_run_length: got %0d want %0d", d, RST_CYCLES + 7);
    end
  endtask

  task automatic test_random_programs();
    logic [7:0] p [$];
    int d;
    for (int it = 0; it < 8; it++) begin
      p.delete();
      for (int i = 0, n = $urandom_range(DEPTH, 1); i < n; i++) p.push_back(8'($urandom));
      do_clear(1'b0);
      load(p);
      run_check($sformatf("random%0d", it), it[0], d);
      n_cmp++;
      if (d !== run_len()) begin
        n_err++;
        $display("FAIL random%0d_run_length: got %0d want %0d", it, d, run_len());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_program();
    test_mul_program();
    test_overflow_clear();
    test_ignore_while_busy();
    test_reset_midrun();
    test_noop_program();
    test_random_programs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_program_feeder.md
# cpu_program_feeder

Upstream sequencer for `stack_cpu`. It stores a short program of opcode/operand pairs, then on command resets the CPU and replays the program onto the CPU's 4-bit `inbits` nibble bus. Every nibble is driven in exactly the cycle the CPU samples it, so a host can run multi-instruction programs without hand-timing pins. Its outputs connect directly to `stack_cpu` `io_in[1]` (rst) and `io_in[5:2]` (inbits).

## Interface
- DEPTH, 16, program entries (power of 2)
- ADDR_W, 4, log2(DEPTH)
- RST_CYCLES, 2, cycles `cpu_rst` is held high at run start (≥1)
- clk  in  1  clock, shared with the CPU
- rst  in  1  reset: synchronous, active-high; clock `clk`
- wr_en  in  1  append `wr_data` to the program
- wr_data  in  8  `{operand[7:4], opcode[3:0]}`
- clear  in  1  empty the program (count←0, overflow←0)
- start  in  1  begin a run (single-cycle pulse)
- cpu_rst  out  1  registered, to CPU rst
- cpu_inbits  out  4  registered, to CPU inbits
- busy  out  1  high from the cycle after an accepted start until `done`
- done  out  1  one-cycle pulse at end of run
- count  out  ADDR_W+1  number of stored entries (0..DEPTH)
- overflow  out  1  sticky: a write was attempted when full

## Operation
- Storage: DEPTH×8 register array with write pointer = `count`.
  - `wr_en` while not busy and count<DEPTH: store the entry and increment count.
  - `wr_en` when count==DEPTH: drop the write and set overflow.
  - `wr_en` or `clear` while busy: ignored.
  - `clear` and `wr_en` in the same cycle: clear wins.
- FSM states: IDLE, CPURST, FETCH, EXEC, FINISH.
  - IDLE: `start` with count>0 → CPURST. `start` with count==0 → FINISH directly, with no `cpu_rst` pulse. `start` while busy is ignored.
  - CPURST: `cpu_rst`=1 for RST_CYCLES cycles, `cpu_inbits`=0. Then → FETCH with pc=0.
  - FETCH (1 cycle): `cpu_inbits`=opcode[pc]. → EXEC with cycle counter k=1.
  - EXEC: `cpu_inbits`=operand[pc] every cycle. Stay until k==L(opcode)-1, then pc+1. If pc+1==count → FINISH, else → FETCH.
  - FINISH (1 cycle): `done`=1, `cpu_inbits`=0 (NOOP). → IDLE.
- Instruction length L, in cycles including fetch:
  - 1 PUSH, 2 POP, 5 SWAP, 6 PUSF, 7 REPL, 8 BIN → 3
  - 3 OUTL, 4 OUTH → 2
  - 9 MUL → 4
  - 0 and A–F (NOOP) → 2
- The operand is held through every EXEC cycle. For PUSH and PUSF/REPL/BIN, the CPU samples it on the final EXEC cycle; for other opcodes it is don't-care. The stored operand is always driven regardless.
- In IDLE: `cpu_rst`=0, `cpu_inbits`=0.
- The stored program survives a run, so it can be re-run with another `start`.

## Timing
- Reset values: cpu_rst=0, cpu_inbits=0, busy=0, done=0, count=0, overflow=0, state IDLE, pc=0. Array contents are don't-care.
- `rst` mid-run aborts immediately. The next cycle shows reset values and no `done` is generated. The CPU is left to its own state; the host re-runs.
- `start` sampled in cycle t:
  - `busy`=1 and `cpu_rst`=1 from cycle t+1 through t+RST_CYCLES.
  - The first opcode appears at t+RST_CYCLES+1, which is exactly the CPU's fetch edge.
- Run latency = RST_CYCLES + ΣL + 1 cycles from start to the `done` cycle inclusive. `busy` falls in the cycle after `done`.
- A write accepted in cycle t is reflected in `count` at t+1. A `start` at t+1 includes it.

## Test plan
- Load {1,3},{1,5},{8,0},{3,x},{4,x} (PUSH 3, PUSH 5, BIN add, OUTL, OUTH), start, drive into `stack_cpu` with output_mode=0 → CPU io_out=8'h88 after `done`. Run = 2+3+3+3+2+2+1 = 16 cycles.
- Load PUSH 7, PUSH 6, MUL, OUTL, POP, OUTH → io_out=8'h2A. Check the MUL window is exactly 4 cycles of `cpu_inbits`.
- Load DEPTH+1 entries → count=16, overflow=1. `clear` → count=0, overflow=0. `start` with count=0 → `done` at t+1, `cpu_rst` never high.
- Assert `start`, `wr_en` and `clear` during a run → all ignored: count unchanged, no restart, run length unchanged.
- Assert `rst` during EXEC of entry 2 → next cycle busy=0, cpu_inbits=0, count=0, no `done` pulse.
- Program of opcodes {0,B,F} with operand 9 → three 2-cycle slots, cpu_inbits sequence 0,9,B,9,F,9, then FINISH 0; CPU stack unchanged.
